// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle variable SLL/SRL/SRA, moving at most STEP_SIZE bits per clock.
// Optional: define SHIFT_UNIT_ROTATE_EN to make in_mode=11 a rotate right (otherwise 11 acts as SLL).
module shift_unit_seq #(
  parameter int BUS_SIZE  = 32,
  parameter int STEP_SIZE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_start,
  input  logic [1:0]                  in_mode,
  input  logic [$clog2(BUS_SIZE)-1:0] in_amount,
  input  logic [BUS_SIZE-1:0]         in_data,
  output logic [BUS_SIZE-1:0]         out_result,
  output logic                        out_busy,
  output logic                        out_done
);
  localparam int AMT_SIZE = $clog2(BUS_SIZE);

  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [1:0] MODE_ROTR = 2'b11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  logic [BUS_SIZE-1:0]  r_work;
  logic [AMT_SIZE-1:0]  r_rem;
  logic [1:0]           r_mode;
  logic [BUS_SIZE-1:0]  r_result;
  logic                 r_busy;
  logic                 r_done;

  logic [AMT_SIZE-1:0]  w_k;
  logic [BUS_SIZE-1:0]  w_next;
  logic [BUS_SIZE-1:0]  w_cand [0:STEP_SIZE];

  // Step size for this cycle: the remaining count, capped at STEP_SIZE.
  always_comb begin
    if (int'(r_rem) < STEP_SIZE) w_k = r_rem;
    else                         w_k = AMT_SIZE'(STEP_SIZE);
  end

  // One fixed-distance candidate per possible step keeps the shifter STEP_SIZE wide, not a barrel.
  for (genvar gi = 0; gi <= STEP_SIZE; gi++) begin : g_step
    logic [BUS_SIZE-1:0]        w_sll;
    logic [BUS_SIZE-1:0]        w_srl;
    logic signed [BUS_SIZE-1:0] w_sra;
    assign w_sll = r_work << gi;
    assign w_srl = r_work >> gi;
    assign w_sra = $signed(r_work) >>> gi;
`ifdef SHIFT_UNIT_ROTATE_EN
    logic [BUS_SIZE-1:0] w_rot;
    assign w_rot = (r_work >> gi) | (r_work << (BUS_SIZE - gi));
    assign w_cand[gi] = (r_mode == MODE_SRL)  ? w_srl :
                        (r_mode == MODE_SRA)  ? w_sra :
                        (r_mode == MODE_ROTR) ? w_rot : w_sll;
`else
    assign w_cand[gi] = (r_mode == MODE_SRL) ? w_srl :
                        (r_mode == MODE_SRA) ? w_sra : w_sll;
`endif
  end

  always_comb begin
    w_next = r_work;
    for (int j = 0; j <= STEP_SIZE; j++) begin
      if (int'(w_k) == j) w_next = w_cand[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_rem    <= '0;
      r_mode   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (in_start) begin
            r_work <= in_data;
            r_mode <= in_mode;
            r_rem  <= in_amount;
            if (in_amount != '0) begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= in_data;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_work <= w_next;
          r_rem  <= r_rem - w_k;
          if (r_rem == w_k) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_result = r_result;
  assign out_busy   = r_busy;
  assign out_done   = r_done;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (BUS_SIZE=32, STEP_SIZE=4); mode-11 expectation follows SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_start;
  logic [1:0]  in_mode;
  logic [4:0]  in_amount;
  logic [31:0] in_data;
  logic [31:0] out_result;
  logic        out_busy;
  logic        out_done;

  int checks   = 0;
  int failures = 0;

  shift_unit_seq #(.BUS_SIZE(32), .STEP_SIZE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_start   (in_start),
    .in_mode    (in_mode),
    .in_amount  (in_amount),
    .in_data    (in_data),
    .out_result (out_result),
    .out_busy   (out_busy),
    .out_done   (out_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at #1 after a posedge (edge 0); start is sampled on edge 1.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [4:0] amt,
                        input logic [31:0] data, input logic [31:0] exp_res,
                        input int exp_edge, input int exp_busy);
    int          done_edge;
    int          busy_cnt;
    logic [31:0] held;
    logic        moved;
    done_edge = -1;
    busy_cnt  = 0;
    moved     = 1'b0;
    held      = out_result;
    in_start  = 1'b1;
    in_mode   = mode;
    in_amount = amt;
    in_data   = data;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        in_start  = 1'b0;
        in_data   = ~data;
        in_amount = ~amt;
        in_mode   = ~mode;
      end
      if (out_busy) busy_cnt++;
      if (out_done) begin
        done_edge = e;
        break;
      end
      if (out_result !== held) moved = 1'b1;
    end
    check({tag, "_done_edge"}, 32'(done_edge), 32'(exp_edge));
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_no_intermediate"}, {31'd0, moved}, 32'd0);
  endtask

  initial begin
    int          n_done;
    int          n_busy;
    logic [31:0] rot_exp;

    reset     = 1'b1;
    in_start  = 1'b0;
    in_mode   = 2'b00;
    in_amount = 5'd0;
    in_data   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", out_result, 32'd0);
    check("reset_busy", {31'd0, out_busy}, 32'd0);
    check("reset_done", {31'd0, out_done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("sll2", 2'b00, 5'd2, 32'hDB6DB6DB, 32'h6DB6DB6C, 2, 1);
    @(posedge clk); #1;
    check("sll2_done_pulse_ends", {31'd0, out_done}, 32'd0);
    check("sll2_result_held", out_result, 32'h6DB6DB6C);

    run_op("sra31", 2'b10, 5'd31, 32'hF0F0F0F0, 32'hFFFFFFFF, 9, 8);
    @(posedge clk); #1;
    run_op("srl31", 2'b01, 5'd31, 32'h80000000, 32'h00000001, 9, 8);
    @(posedge clk); #1;
    run_op("amt0", 2'b00, 5'd0, 32'h33333333, 32'h33333333, 1, 0);
    @(posedge clk); #1;
    run_op("sra4", 2'b10, 5'd4, 32'h80000000, 32'hF8000000, 2, 1);
    @(posedge clk); #1;
    run_op("srl5", 2'b01, 5'd5, 32'hFFFFFFFF, 32'h07FFFFFF, 3, 2);
    @(posedge clk); #1;

    // Ignored start during SHIFT, then back-to-back start in the DONE cycle.
    in_start = 1'b1; in_mode = 2'b01; in_amount = 5'd8; in_data = 32'h12345678;
    @(posedge clk); #1;
    in_start = 1'b0;
    check("b2b_first_busy", {31'd0, out_busy}, 32'd1);
    @(posedge clk); #1;
    in_start = 1'b1; in_mode = 2'b00; in_amount = 5'd1; in_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("b2b_first_done", {31'd0, out_done}, 32'd1);
    check("b2b_first_result", out_result, 32'h00123456);
    in_start = 1'b1; in_mode = 2'b00; in_amount = 5'd4; in_data = 32'h0000000F;
    @(posedge clk); #1;
    in_start = 1'b0;
    check("b2b_second_busy", {31'd0, out_busy}, 32'd1);
    check("b2b_result_kept", out_result, 32'h00123456);
    @(posedge clk); #1;
    check("b2b_second_done", {31'd0, out_done}, 32'd1);
    check("b2b_second_result", out_result, 32'h000000F0);
    @(posedge clk); #1;

    // Reset during the 3rd SHIFT cycle of SRL by 20.
    in_start = 1'b1; in_mode = 2'b01; in_amount = 5'd20; in_data = 32'hFFFF0000;
    @(posedge clk); #1;
    in_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_busy_before", {31'd0, out_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_result", out_result, 32'd0);
    check("midrst_busy", {31'd0, out_busy}, 32'd0);
    check("midrst_done", {31'd0, out_done}, 32'd0);
    #1;
    reset = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_done) n_done++;
      if (out_busy) n_busy++;
    end
    check("midrst_no_done_after", 32'(n_done), 32'd0);
    check("midrst_no_busy_after", 32'(n_busy), 32'd0);

    run_op("sll1_after_rst", 2'b00, 5'd1, 32'h00000001, 32'h00000002, 2, 1);
    @(posedge clk); #1;

`ifdef SHIFT_UNIT_ROTATE_EN
    rot_exp = 32'h80000000;
`else
    rot_exp = 32'h00000002;
`endif
    run_op("mode11", 2'b11, 5'd1, 32'h00000001, rot_exp, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
